// File: rtl/aes192_dec_sched_pkg.sv
// Shared widths and FSM state encoding for the AES-192 decrypt scheduler.
package aes_dec_sched_pkg;
  localparam int KEY_W = 192;
  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEY     = 2'd1,
    CT      = 2'd2,
    WAIT_PT = 2'd3
  } sched_state_t;
endpackage

// File: rtl/aes192_dec_sched_if.sv
// Bundle of requester, decrypt-core and response signals around the scheduler.
interface aes192_dec_sched_if import aes_dec_sched_pkg::*; #(
  parameter int NREQ = 4
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_vld;
  logic [NREQ*KEY_W-1:0] req_kt;
  logic [NREQ*BLK_W-1:0] req_ct;
  logic [NREQ-1:0]       req_rdy;
  logic [KEY_W-1:0]      kt;
  logic                  kt_vld;
  logic                  kt_rdy;
  logic [BLK_W-1:0]      ct;
  logic                  ct_vld;
  logic                  ct_rdy;
  logic [BLK_W-1:0]      pt;
  logic                  pt_vld;
  logic [BLK_W-1:0]      rsp_pt;
  logic                  rsp_vld;
  logic [IDW-1:0]        rsp_id;

  modport slave (
    input  req_vld, req_kt, req_ct, kt_rdy, ct_rdy, pt, pt_vld,
    output req_rdy, kt, kt_vld, ct, ct_vld, rsp_pt, rsp_vld, rsp_id
  );

  modport master (
    output req_vld, req_kt, req_ct, kt_rdy, ct_rdy, pt, pt_vld,
    input  req_rdy, kt, kt_vld, ct, ct_vld, rsp_pt, rsp_vld, rsp_id
  );
endinterface

// File: rtl/aes192_dec_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) begin
      s = s - NREQ;
    end else begin
      s = s;
    end
    return IDW'(s);
  endfunction

  // scan NREQ positions starting at the pointer, keep the first hit
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[wrap_idx(ptr, k)]) begin
        gnt[wrap_idx(ptr, k)] = 1'b1;
        idx = wrap_idx(ptr, k);
        any = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/aes192_dec_sched.sv
// Round-robin scheduler sharing one AES-192 decrypt core among NREQ requesters.
// Define SCHED_KEY_REUSE_EN to skip reloading a key the core already holds.
module aes192_dec_sched import aes_dec_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic               clk,
  input logic               rst,
  aes192_dec_sched_if.slave bus
);

  sched_state_t     state_r, state_nx_s;
  logic [NREQ-1:0]  gnt_oh_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic             gnt_any_s;
  logic [IDW-1:0]   ptr_r, gid_r;
  logic [KEY_W-1:0] gnt_kt_s;
  logic [BLK_W-1:0] gnt_ct_s;
  logic [KEY_W-1:0] kt_arr_s [NREQ];
  logic [BLK_W-1:0] ct_arr_s [NREQ];
  logic             grant_s, key_go_s, ct_go_s, pt_go_s, key_hit_s;

  logic [NREQ-1:0]  req_rdy_r;
  logic [KEY_W-1:0] kt_r;
  logic             kt_vld_r;
  logic [BLK_W-1:0] ct_r;
  logic             ct_vld_r;
  logic [BLK_W-1:0] rsp_pt_r;
  logic             rsp_vld_r;
  logic [IDW-1:0]   rsp_id_r;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (bus.req_vld),
    .ptr (ptr_r),
    .gnt (gnt_oh_s),
    .idx (gnt_idx_s),
    .any (gnt_any_s)
  );

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign kt_arr_s[i] = bus.req_kt[i*KEY_W +: KEY_W];
    assign ct_arr_s[i] = bus.req_ct[i*BLK_W +: BLK_W];
  end

  assign gnt_kt_s = kt_arr_s[gnt_idx_s];
  assign gnt_ct_s = ct_arr_s[gnt_idx_s];

`ifdef SCHED_KEY_REUSE_EN
  logic [KEY_W-1:0] loaded_key_r;
  logic             key_loaded_vld_r;

  assign key_hit_s = key_loaded_vld_r && (gnt_kt_s == loaded_key_r);

  // remember the key last handed to the core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded_key_r     <= '0;
      key_loaded_vld_r <= 1'b0;
    end else if (key_go_s) begin
      loaded_key_r     <= kt_r;
      key_loaded_vld_r <= 1'b1;
    end
  end
`else
  assign key_hit_s = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // next-state and per-cycle strobes
  always_comb begin
    state_nx_s = state_r;
    grant_s    = 1'b0;
    key_go_s   = 1'b0;
    ct_go_s    = 1'b0;
    pt_go_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (gnt_any_s) begin
          grant_s    = 1'b1;
          state_nx_s = key_hit_s ? CT : KEY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      KEY: begin
        if (bus.kt_rdy) begin
          key_go_s   = 1'b1;
          state_nx_s = CT;
        end else begin
          state_nx_s = KEY;
        end
      end
      CT: begin
        if (bus.ct_rdy) begin
          ct_go_s    = 1'b1;
          state_nx_s = WAIT_PT;
        end else begin
          state_nx_s = CT;
        end
      end
      WAIT_PT: begin
        if (bus.pt_vld) begin
          pt_go_s    = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT_PT;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // grant bookkeeping, data latches and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r     <= '0;
      gid_r     <= '0;
      req_rdy_r <= '0;
      kt_r      <= '0;
      kt_vld_r  <= 1'b0;
      ct_r      <= '0;
      ct_vld_r  <= 1'b0;
      rsp_pt_r  <= '0;
      rsp_vld_r <= 1'b0;
      rsp_id_r  <= '0;
    end else begin
      req_rdy_r <= grant_s ? gnt_oh_s : '0;
      kt_vld_r  <= key_go_s;
      ct_vld_r  <= ct_go_s;
      rsp_vld_r <= pt_go_s;
      if (grant_s) begin
        kt_r  <= gnt_kt_s;
        ct_r  <= gnt_ct_s;
        gid_r <= gnt_idx_s;
        ptr_r <= (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + 1'b1;
      end
      if (pt_go_s) begin
        rsp_pt_r <= bus.pt;
        rsp_id_r <= gid_r;
      end
    end
  end

  assign bus.req_rdy = req_rdy_r;
  assign bus.kt      = kt_r;
  assign bus.kt_vld  = kt_vld_r;
  assign bus.ct      = ct_r;
  assign bus.ct_vld  = ct_vld_r;
  assign bus.rsp_pt  = rsp_pt_r;
  assign bus.rsp_vld = rsp_vld_r;
  assign bus.rsp_id  = rsp_id_r;

endmodule
